simmem_linkedlist_bank_rr: RTL

Per-ID linked-list reorder buffer for the simulated memory controller. It stores incoming structs (ID in LSBs) in a shared flop-array pool, one linked list per ID. It releases the oldest entry of a release-enabled, non-empty ID through a valid/ready output.
It generalises the previous linked-list bank in four ways: arbitrary ID count, selectable fixed-priority/round-robin arbitration, simultaneous push and pop, and a locked output grant. It also reports occupancy and per-ID status.

---
 rtl/simmem_linkedlist_bank_rr.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/simmem_linkedlist_bank_rr.sv
// Per-ID linked-list reorder buffer: shared flop pool holding one FIFO list per ID,
// released through a valid/ready port by fixed-priority or round-robin arbitration.
module simmem_linkedlist_bank_rr #(
    parameter int StructWidth   = 64,
    parameter int TotalCapacity = 32,
    parameter int NumIds        = 8,
    parameter int ArbMode       = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumIds-1:0]                    release_en_i,
    input  logic [StructWidth-1:0]               data_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    output logic [StructWidth-1:0]               data_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [$clog2(TotalCapacity+1)-1:0]   occupancy_o,
    output logic [NumIds-1:0]                    id_nonempty_o
);

    localparam int IdWidth   = (NumIds > 1) ? $clog2(NumIds) : 1;
    localparam int AddrWidth = $clog2(TotalCapacity);
    localparam int OccWidth  = $clog2(TotalCapacity + 1);
    localparam int CntWidth  = AddrWidth + 1;
    localparam int PayWidth  = StructWidth - IdWidth;

    logic [PayWidth-1:0]  payload_q [TotalCapacity];
    logic [AddrWidth-1:0] next_q    [TotalCapacity];
    logic [TotalCapacity-1:0] valid_q;
    logic [AddrWidth-1:0] head_q    [NumIds];
    logic [AddrWidth-1:0] tail_q    [NumIds];
    logic [CntWidth-1:0]  count_q   [NumIds];
    logic [IdWidth-1:0]   rr_q;
    logic [IdWidth-1:0]   locked_id_q;
    logic                 lock_q;
    logic [OccWidth-1:0]  occupancy_q;

    logic [AddrWidth-1:0] free_slot;
    logic [NumIds-1:0]    eligible;
    logic [NumIds-1:0]    push_sel;
    logic [NumIds-1:0]    pop_sel;
    logic [IdWidth-1:0]   arb_id;
    logic [IdWidth-1:0]   grant;
    logic [IdWidth-1:0]   push_id;
    logic                 any_eligible;
    logic                 push;
    logic                 push_ok;
    logic                 pop;

    // Free slot comes from registered valid bits, so a slot freed this cycle is not reused.
    always_comb begin
        free_slot = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_slot = AddrWidth'(i);
        end
    end

    always_comb begin
        eligible      = '0;
        id_nonempty_o = '0;
        for (int k = 0; k < NumIds; k++) begin
            id_nonempty_o[k] = (count_q[k] != '0);
            eligible[k]      = (count_q[k] != '0) && release_en_i[k];
        end
    end

    always_comb begin
        logic found;
        int   idx;
        found        = 1'b0;
        idx          = 0;
        arb_id       = '0;
        any_eligible = |eligible;
        if (ArbMode == 0) begin
            for (int k = NumIds - 1; k >= 0; k--) begin
                if (eligible[k]) arb_id = IdWidth'(k);
            end
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                idx = int'(rr_q) + i;
                if (idx >= NumIds) idx = idx - NumIds;
                if (!found && eligible[idx]) begin
                    found  = 1'b1;
                    arb_id = IdWidth'(idx);
                end
            end
        end
    end

    assign grant       = lock_q ? locked_id_q : arb_id;
    assign out_valid_o = lock_q | any_eligible;
    assign data_o      = {payload_q[head_q[grant]], grant};
    assign in_ready_o  = (occupancy_q < OccWidth'(TotalCapacity));
    assign occupancy_o = occupancy_q;

    // Out-of-range IDs still complete the handshake but leave no trace.
    assign push_id = data_i[IdWidth-1:0];
    assign push    = in_valid_i & in_ready_o;
    assign push_ok = push & (int'(push_id) < NumIds);
    assign pop     = out_valid_o & out_ready_i;

    always_comb begin
        push_sel = '0;
        pop_sel  = '0;
        for (int k = 0; k < NumIds; k++) begin
            push_sel[k] = push_ok && (push_id == IdWidth'(k));
            pop_sel[k]  = pop && (grant == IdWidth'(k));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            rr_q        <= '0;
            lock_q      <= 1'b0;
            occupancy_q <= '0;
            for (int k = 0; k < NumIds; k++) count_q[k] <= '0;
        end else begin
            if (pop)     valid_q[head_q[grant]] <= 1'b0;
            if (push_ok) valid_q[free_slot]     <= 1'b1;
            for (int k = 0; k < NumIds; k++) begin
                count_q[k] <= count_q[k] + CntWidth'(push_sel[k]) - CntWidth'(pop_sel[k]);
            end
            occupancy_q <= occupancy_q + OccWidth'(push_ok) - OccWidth'(pop);
            if (pop) begin
                lock_q <= 1'b0;
                if (ArbMode == 1) begin
                    rr_q <= (grant == IdWidth'(NumIds - 1)) ? '0 : grant + 1'b1;
                end
            end else if (out_valid_o) begin
                // Stalled output: freeze the grant until the consumer accepts it.
                lock_q      <= 1'b1;
                locked_id_q <= grant;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            payload_q[free_slot] <= data_i[StructWidth-1:IdWidth];
            if (count_q[push_id] != '0) next_q[tail_q[push_id]] <= free_slot;
        end
        for (int k = 0; k < NumIds; k++) begin
            // A push into a list that is empty, or emptied by this cycle's pop, starts it fresh.
            if (push_sel[k] && ((count_q[k] == '0) || (pop_sel[k] && (count_q[k] == CntWidth'(1))))) begin
                head_q[k] <= free_slot;
            end else if (pop_sel[k]) begin
                head_q[k] <= next_q[head_q[k]];
            end
            if (push_sel[k]) tail_q[k] <= free_slot;
        end
    end

endmodule
